// File: rtl/sprite_palette_bank.sv
// Multi-palette 12-bit RGB lookup for sprite pixels, with transparency flag and frame-counted hit flash.
// Latency 2 cycles from rd_valid to out_valid; one lookup per cycle, no backpressure.
module sprite_palette_bank #(
    parameter int IDX_W        = 3,
    parameter int NUM_PAL      = 4,
    parameter int PAL_W        = 2,
    parameter int TRANSP_IDX   = 0,
    parameter int FLASH_FRAMES = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [PAL_W-1:0] wr_pal,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [11:0]      wr_rgb,
    input  logic             rd_valid,
    input  logic [PAL_W-1:0] rd_pal,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             transp_en,
    input  logic             vsync_tick,
    input  logic             flash_start,
    output logic [3:0]       red,
    output logic [3:0]       green,
    output logic [3:0]       blue,
    output logic             out_valid,
    output logic             out_transparent,
    output logic             flash_active
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] TIDX = IDX_W'(TRANSP_IDX);
    localparam logic [7:0] LAST_FRAME = 8'(FLASH_FRAMES - 1);

    typedef enum logic {S_IDLE, S_FLASH} state_t;

    function automatic logic [11:0] pal0_init(input int i);
        case (i)
            0:       return 12'h0E1;
            1:       return 12'h000;
            2:       return 12'h04D;
            3:       return 12'hB86;
            4:       return 12'hECA;
            5:       return 12'hD30;
            6:       return 12'h322;
            7:       return 12'h090;
            default: return 12'h000;
        endcase
    endfunction

    logic [11:0]      r_pal [NUM_PAL][DEPTH];
    state_t           r_state, w_state_nxt;
    logic [7:0]       r_cnt, w_cnt_nxt;
    logic             r_flash_active;
    logic             r_s1_vld, r_s1_transp;
    logic [11:0]      r_s1_rgb;
    logic             r_out_vld, r_out_transp;
    logic [11:0]      r_out_rgb;

    logic             w_wr_ok, w_rd_oor, w_transp, w_white;
    logic [PAL_W-1:0] w_wr_pal, w_rd_pal;
    logic [11:0]      w_rd_rgb;

    // Palette indices are clamped to 0 when out of range so the array is never indexed past NUM_PAL.
    assign w_wr_ok  = wr_en && (32'(wr_pal) < NUM_PAL);
    assign w_wr_pal = (32'(wr_pal) < NUM_PAL) ? wr_pal : '0;
    assign w_rd_oor = !(32'(rd_pal) < NUM_PAL);
    assign w_rd_pal = w_rd_oor ? '0 : rd_pal;
    assign w_transp = w_rd_oor || (transp_en && (rd_idx == TIDX));
    assign w_white  = (r_state == S_FLASH) && !r_cnt[0] && !w_transp;
    assign w_rd_rgb = w_rd_oor ? 12'h000 : (w_white ? 12'hFFF : r_pal[w_rd_pal][rd_idx]);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int p = 0; p < NUM_PAL; p++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_pal[p][i] <= (p == 0) ? pal0_init(i) : 12'h000;
                end
            end
        end else if (w_wr_ok) begin
            r_pal[w_wr_pal][wr_idx] <= wr_rgb;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (flash_start) begin
                    w_state_nxt = S_FLASH;
                    w_cnt_nxt   = 8'd0;
                end
            end
            S_FLASH: begin
                // A restart takes priority over a coincident frame tick.
                if (flash_start) begin
                    w_cnt_nxt = 8'd0;
                end else if (vsync_tick) begin
                    if (r_cnt == LAST_FRAME) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 8'd0;
            r_flash_active <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_flash_active <= (w_state_nxt == S_FLASH);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_vld     <= 1'b0;
            r_s1_transp  <= 1'b0;
            r_s1_rgb     <= 12'h000;
            r_out_vld    <= 1'b0;
            r_out_transp <= 1'b0;
            r_out_rgb    <= 12'h000;
        end else begin
            r_s1_vld <= rd_valid;
            if (rd_valid) begin
                r_s1_transp <= w_transp;
                r_s1_rgb    <= w_rd_rgb;
            end
            r_out_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_out_transp <= r_s1_transp;
                r_out_rgb    <= r_s1_rgb;
            end
        end
    end

    assign red             = r_out_rgb[11:8];
    assign green           = r_out_rgb[7:4];
    assign blue            = r_out_rgb[3:0];
    assign out_valid       = r_out_vld;
    assign out_transparent = r_out_transp;
    assign flash_active    = r_flash_active;
endmodule

// File: tb/tb_sprite_palette_bank.sv
// Scoreboard bench for sprite_palette_bank with NUM_PAL=3 so palette 3 is out of range.
module tb_sprite_palette_bank;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_pal = '0;
    logic [2:0]  wr_idx = '0;
    logic [11:0] wr_rgb = '0;
    logic        rd_valid = 1'b0;
    logic [1:0]  rd_pal = '0;
    logic [2:0]  rd_idx = '0;
    logic        transp_en = 1'b0;
    logic        vsync_tick = 1'b0;
    logic        flash_start = 1'b0;
    logic [3:0]  red, green, blue;
    logic        out_valid, out_transparent, flash_active;

    sprite_palette_bank #(.IDX_W(3), .NUM_PAL(3), .PAL_W(2), .TRANSP_IDX(0), .FLASH_FRAMES(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .wr_en(wr_en), .wr_pal(wr_pal), .wr_idx(wr_idx), .wr_rgb(wr_rgb),
        .rd_valid(rd_valid), .rd_pal(rd_pal), .rd_idx(rd_idx), .transp_en(transp_en),
        .vsync_tick(vsync_tick), .flash_start(flash_start),
        .red(red), .green(green), .blue(blue),
        .out_valid(out_valid), .out_transparent(out_transparent), .flash_active(flash_active)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [11:0] rgb;
        logic        tr;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [11:0] m_pal [4][8];
    logic        m_flash;
    logic [7:0]  m_cnt;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        logic [11:0] init [8];
        init = '{12'h0E1, 12'h000, 12'h04D, 12'hB86, 12'hECA, 12'hD30, 12'h322, 12'h090};
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 8; i++)
                m_pal[p][i] = (p == 0) ? init[i] : 12'h000;
        m_flash = 1'b0;
        m_cnt   = 8'd0;
    endtask

    // Called at a falling edge with inputs already set: queue the expected result, advance the model, wait one cycle.
    task automatic cycle();
        exp_t e;
        logic oor;
        check("flash_active", flash_active, m_flash);
        if (rd_valid) begin
            oor   = (rd_pal >= 2'd3);
            e.tr  = oor || (transp_en && rd_idx == 3'd0);
            e.rgb = oor ? 12'h000 : ((m_flash && !m_cnt[0] && !e.tr) ? 12'hFFF : m_pal[rd_pal][rd_idx]);
            e.cyc = cyc;
            q.push_back(e);
        end
        if (wr_en && wr_pal < 2'd3) m_pal[wr_pal][wr_idx] = wr_rgb;
        if (flash_start) begin
            m_flash = 1'b1;
            m_cnt   = 8'd0;
        end else if (m_flash && vsync_tick) begin
            if (m_cnt == 8'd7) begin
                m_flash = 1'b0;
                m_cnt   = 8'd0;
            end else begin
                m_cnt = m_cnt + 8'd1;
            end
        end
        @(negedge Clk);
        wr_en = 1'b0; rd_valid = 1'b0; vsync_tick = 1'b0; flash_start = 1'b0;
    endtask

    task automatic rd(input logic [1:0] p, input logic [2:0] i, input logic te);
        rd_valid = 1'b1; rd_pal = p; rd_idx = i; transp_en = te;
    endtask

    task automatic wr(input logic [1:0] p, input logic [2:0] i, input logic [11:0] d);
        wr_en = 1'b1; wr_pal = p; wr_idx = i; wr_rgb = d;
    endtask

    always @(negedge Clk) begin
        exp_t e;
        if (!Reset && out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("rgb", {red, green, blue}, e.rgb);
                check("transparent", out_transparent, e.tr);
                check("latency", cyc, e.cyc + 2);
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rgb"}, {red, green, blue}, 12'h000);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_transparent"}, out_transparent, 1'b0);
        check({tag, "_flash_active"}, flash_active, 1'b0);
    endtask

    initial begin
        model_reset();
        #1 check_outputs_zero("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // Palette 0 defaults, back-to-back.
        for (int i = 0; i < 8; i++) begin
            rd(2'd0, 3'(i), 1'b0);
            cycle();
        end
        repeat (3) cycle();

        // Read-during-write returns old data; then new data.
        wr(2'd2, 3'd5, 12'hABC); rd(2'd2, 3'd5, 1'b0); cycle();
        rd(2'd2, 3'd5, 1'b0); cycle();
        // Out-of-range write must not land anywhere.
        wr(2'd3, 3'd3, 12'h555); cycle();
        rd(2'd0, 3'd3, 1'b0); cycle();
        rd(2'd1, 3'd3, 1'b0); cycle();
        rd(2'd2, 3'd3, 1'b0); cycle();
        rd(2'd3, 3'd3, 1'b0); cycle();

        // Transparency.
        rd(2'd0, 3'd0, 1'b1); cycle();
        rd(2'd0, 3'd0, 1'b0); cycle();
        rd(2'd3, 3'd0, 1'b0); cycle();
        rd(2'd0, 3'd4, 1'b1); cycle();
        repeat (3) cycle();

        // Flash over 8 frames, with a transparent read each frame.
        flash_start = 1'b1; cycle();
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 1) rd(2'd0, 3'd0, 1'b1);
                else        rd(2'd0, 3'd3, 1'b0);
                vsync_tick = (k == 3);
                cycle();
            end
        end
        for (int k = 0; k < 4; k++) begin
            rd(2'd0, 3'd3, 1'b0); cycle();
        end

        // Restart coinciding with the 5th tick.
        flash_start = 1'b1; cycle();
        for (int t = 1; t <= 13; t++) begin
            rd(2'd0, 3'd3, 1'b0); cycle();
            rd(2'd0, 3'd3, 1'b0); vsync_tick = 1'b1; flash_start = (t == 5); cycle();
        end
        repeat (3) cycle();

        // Reset mid-flash with pipeline full and palette 0 modified.
        wr(2'd0, 3'd2, 12'h123); flash_start = 1'b1; cycle();
        rd(2'd0, 3'd2, 1'b0); cycle();
        rd(2'd0, 3'd5, 1'b0); cycle();
        rd(2'd0, 3'd6, 1'b0); cycle();
        check("pre_reset_flash_active", flash_active, 1'b1);
        #2 Reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        q.delete();
        model_reset();
        @(negedge Clk);
        check_outputs_zero("held_reset");
        Reset = 1'b0;
        rd(2'd0, 3'd2, 1'b0); cycle();
        rd(2'd0, 3'd0, 1'b0); cycle();

        repeat (4) cycle();
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Programmable multi-palette colour lookup for sprite pixels.
- Maps a palette select plus a colour index to 12-bit RGB (4:4:4) through a 2-stage registered pipeline.
- Palettes are rewritable at runtime. Adds a transparency flag and a frame-counted hit-flash effect.
- Sits between the sprite ROM/index fetch and the VGA colour mux.

Parameters:
- IDX_W, 3, colour index width; each palette holds 2**IDX_W entries.
- NUM_PAL, 4, number of palettes, range 1..16.
- PAL_W, 2, palette select width; must satisfy 2**PAL_W >= NUM_PAL.
- TRANSP_IDX, 0, index reported as transparent.
- FLASH_FRAMES, 8, length of a flash sequence in frames, range 1..255.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- wr_en  in  1  palette write strobe
- wr_pal  in  PAL_W  palette to write
- wr_idx  in  IDX_W  entry to write
- wr_rgb  in  12  {R,G,B} write data
- rd_valid  in  1  lookup request
- rd_pal  in  PAL_W  palette select
- rd_idx  in  IDX_W  colour index
- transp_en  in  1  enables transparency reporting
- vsync_tick  in  1  one-cycle pulse per frame
- flash_start  in  1  one-cycle pulse, starts or restarts a flash
- red, green, blue  out  4 each  looked-up colour
- out_valid  out  1  red/green/blue/out_transparent are valid
- out_transparent  out  1  pixel is transparent
- flash_active  out  1  flash sequence in progress

Behaviour:
- Reset (asynchronous, active-high; an assertion mid-operation takes effect immediately):
  - All pipeline outputs go to 0: red, green, blue, out_valid, out_transparent, flash_active.
  - FSM goes to IDLE; frame counter goes to 0.
  - Palette 0 entries 0..7 load 0x0E1, 0x000, 0x04D, 0xB86, 0xECA, 0xD30, 0x322, 0x090. Entries at or above 8 (when IDX_W > 3) load 0.
  - Palettes 1..NUM_PAL-1 load 0.
  - Storage is flop-based.
- Writes:
  - When wr_en is high at a rising edge, entry [wr_pal][wr_idx] takes wr_rgb.
  - If wr_pal >= NUM_PAL, the write is ignored.
- Read pipeline, latency 2:
  - Request sampled at edge E: stage 1 registers the array value, palette-range check, transparency and flash state.
  - At edge E+1 the outputs register the stage-1 result.
  - One request accepted per cycle. No stall, no backpressure.
  - out_valid follows rd_valid delayed by 2 cycles.
  - When out_valid is 0, colour outputs hold their last values.
- Read and write in the same cycle to the same entry: the read returns the old value. The next cycle's read returns the new value.
- Out-of-range read (rd_pal >= NUM_PAL): RGB = 0x000 and out_transparent = 1.
- out_transparent = transp_en AND (rd_idx == TRANSP_IDX), or the out-of-range case. RGB is still the table value, except for the out-of-range case.
- Flash FSM:
  - IDLE: flash_start -> FLASH, frame counter = 0.
  - FLASH: each vsync_tick increments the counter. When the counter reaches FLASH_FRAMES-1 and vsync_tick arrives -> IDLE, counter = 0.
  - flash_start during FLASH restarts the counter to 0 and stays in FLASH.
  - flash_start and vsync_tick in the same cycle: the restart wins.
  - flash_active = 1 while in FLASH (registered, visible the cycle after the transition edge).
  - While in FLASH with counter bit 0 = 0, opaque in-range pixels output 0xFFF. Transparent pixels keep their table value.
  - Flash state is sampled in stage 1, alongside the request.

Test Plan:
- Reset, then read pal 0 idx 0..7 back-to-back -> outputs 0x0E1, 0x000, 0x04D, 0xB86, 0xECA, 0xD30, 0x322, 0x090. out_valid is high exactly 2 cycles after each rd_valid, and the stream is gapless.
- Write pal 2 idx 5 = 0xABC while reading pal 2 idx 5 in the same cycle, then read again -> first result 0x000, second 0xABC. A write to pal 3 with NUM_PAL=3 has no effect.
- transp_en=1, read pal 0 idx 0 -> RGB 0x0E1 with out_transparent=1. With transp_en=0 -> out_transparent=0. rd_pal=3 with NUM_PAL=3 -> 0x000 with out_transparent=1.
- flash_start, then continuous reads of pal 0 idx 3 across 8 vsync_ticks -> output alternates 0xFFF/0xB86 per frame, starting with 0xFFF. flash_active drops after the 8th tick.
- flash_start on the same cycle as the 5th vsync_tick -> counter restarts, and flash_active stays high for 8 more ticks.
- Assert Reset mid-flash with a pipeline full and palette 0 modified -> all outputs 0 immediately and FSM in IDLE. After release, pal 0 idx 2 reads 0x04D.
